// File: rtl/nios2_oci_dct_pkg.sv
// rtl/nios2_oci_dct_pkg.sv - shared state type, default sizing and atom encodings for the DCT frame controller
package nios2_oci_dct_pkg;

   localparam int DCT_ATOM_W_DEF      = 2;
   localparam int DCT_DEPTH_DEF       = 15;
   localparam int DCT_TIMEOUT_CYC_DEF = 64;

   localparam logic [1:0] ATOM_NONE      = 2'b00;
   localparam logic [1:0] ATOM_TAKEN     = 2'b01;
   localparam logic [1:0] ATOM_NOT_TAKEN = 2'b10;
   localparam logic [1:0] ATOM_EXCEPTION = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_EMIT,
      ST_DRAIN,
      ST_DONE
   } dct_state_e;

endpackage

// File: rtl/nios2_oci_dct_rr_arb.sv
// rtl/nios2_oci_dct_rr_arb.sv - two-way round-robin grant between instruction (bit 0) and data (bit 1) trace atoms
module nios2_oci_dct_rr_arb (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   // ptr_q low favours the instruction source on a tie
   logic ptr_q, ptr_d;

   // one-hot grant; after any grant the pointer favours the other source
   always_comb begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
      if (en) begin
         if (req == 2'b11) begin
            gnt = ptr_q ? 2'b10 : 2'b01;
         end else begin
            gnt = req;
         end
         if (gnt[0]) begin
            ptr_d = 1'b1;
         end else if (gnt[1]) begin
            ptr_d = 1'b0;
         end
      end
   end

   // pointer register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/nios2_oci_dct_ctrl.sv
// rtl/nios2_oci_dct_ctrl.sv - packs trace atoms into frames; optional idle flush via NIOS2_OCI_DCT_TIMEOUT_EN
module nios2_oci_dct_ctrl
   import nios2_oci_dct_pkg::*;
#(
   parameter int ATOM_W      = DCT_ATOM_W_DEF,
   parameter int DEPTH       = DCT_DEPTH_DEF,
   parameter int TIMEOUT_CYC = DCT_TIMEOUT_CYC_DEF
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          itr_req,
   input  logic [ATOM_W-1:0]             itr_atom,
   output logic                          itr_ack,
   input  logic                          dtr_req,
   input  logic [ATOM_W-1:0]             dtr_atom,
   output logic                          dtr_ack,
   output logic [ATOM_W*DEPTH-1:0]       dct_buffer,
   output logic [$clog2(DEPTH+1)-1:0]    dct_count,
   output logic                          dct_valid,
   input  logic                          dct_ready,
   input  logic                          test_ending,
   output logic                          test_has_ended
);

   localparam int FRAME_W = ATOM_W * DEPTH;
   localparam int CNT_W   = $clog2(DEPTH + 1);

   dct_state_e          state_q, state_d;
   logic [FRAME_W-1:0]  buf_q, buf_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          gnt;
   logic                arb_en;
   logic                accept;
   logic                to_fire;
   logic [ATOM_W-1:0]   atom_sel;

   // atoms are only taken while collecting and when no end-of-test request competes
   assign arb_en = reset_n && !test_ending && (state_q == ST_IDLE || state_q == ST_FILL);

   nios2_oci_dct_rr_arb u_arb (
      .clk   (clk),
      .rst_n (reset_n),
      .en    (arb_en),
      .req   ({dtr_req, itr_req}),
      .gnt   (gnt)
   );

   assign itr_ack  = gnt[0];
   assign dtr_ack  = gnt[1];
   assign accept   = |gnt;
   assign atom_sel = gnt[1] ? dtr_atom : itr_atom;

`ifdef NIOS2_OCI_DCT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
   logic [TO_W-1:0] to_q, to_d;

   // counts consecutive idle FILL cycles; anything else restarts it
   always_comb begin
      to_d    = '0;
      to_fire = 1'b0;
      if (state_q == ST_FILL && !accept && !test_ending) begin
         if (to_q == TO_W'(TIMEOUT_CYC - 1)) begin
            to_fire = 1'b1;
         end else begin
            to_d = to_q + 1'b1;
         end
      end
   end

   // idle counter register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         to_q <= '0;
      end else begin
         to_q <= to_d;
      end
   end
`else
   // no idle flush in this build; the parameter has no effect
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYC;
   assign to_fire = 1'b0;
`endif

   // frame sequencing: collect, offer full or partial frame, finish on end-of-test
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_FILL: begin
            if (test_ending) begin
               state_d = (cnt_q != '0) ? ST_DRAIN : ST_DONE;
            end else if (accept) begin
               for (int i = 0; i < DEPTH; i++) begin
                  if (cnt_q == CNT_W'(i)) begin
                     buf_d[i*ATOM_W +: ATOM_W] = atom_sel;
                  end
               end
               cnt_d   = cnt_q + 1'b1;
               state_d = (cnt_q == CNT_W'(DEPTH - 1)) ? ST_EMIT : ST_FILL;
            end else if (to_fire) begin
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (dct_ready) begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (dct_ready) begin
               buf_d   = '0;
               cnt_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_DONE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // state, frame and count registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         buf_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign dct_buffer     = buf_q;
   assign dct_count      = cnt_q;
   assign dct_valid      = (state_q == ST_EMIT) || (state_q == ST_DRAIN);
   assign test_has_ended = (state_q == ST_DONE);

endmodule
